// File: rtl/axi_stream_hash_bridge.sv
// AXI4 slave bridging bus bursts to the hash core: writes fill an input FIFO,
// reads drain a core-fed output FIFO or return status.
module axi_stream_hash_bridge #(
    parameter int DATA_W    = 32,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [31:0]       AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [31:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [DATA_W-1:0] core_in_data,
    output logic              core_in_last,
    output logic              core_in_valid,
    input  logic              core_in_ready,
    input  logic [DATA_W-1:0] core_out_data,
    input  logic              core_out_valid,
    output logic              core_out_ready,
    output logic [1:0]        w_state_dbg,
    output logic [1:0]        r_state_dbg
);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_CW = OUT_AW + 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [7:0] aw_addr_q, ar_addr_q, r_cnt_q;
    logic hold_v;
    logic [DATA_W-1:0] hold_d, rdata_live, status;

    // Input FIFO: {last tag, data}
    logic [DATA_W:0]   in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  in_wr_ptr, in_rd_ptr;
    logic [IN_CW-1:0]  in_count;
    logic [DATA_W:0]   in_din;
    logic in_push, in_push_ok, in_pop_ok, in_full, in_empty;

    logic [DATA_W-1:0] out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_ptr, out_rd_ptr;
    logic [OUT_CW-1:0] out_count;
    logic out_push_ok, out_pop, out_pop_ok, out_full, out_empty;

    logic w_bad, r_is_pop, r_is_stat, r_bad;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{AWADDR[31:8], ARADDR[31:8]};

    assign in_full    = (in_count == IN_CW'(IN_DEPTH));
    assign in_empty   = (in_count == '0);
    assign in_push_ok = in_push && !in_full;
    assign in_pop_ok  = core_in_valid && core_in_ready;
    assign in_din     = {WLAST && (aw_addr_q == 8'h04), WDATA};

    assign core_in_valid = !in_empty && !ARESET;
    assign core_in_data  = in_mem[in_rd_ptr][DATA_W-1:0];
    assign core_in_last  = in_mem[in_rd_ptr][DATA_W];

    assign out_full       = (out_count == OUT_CW'(OUT_DEPTH));
    assign out_empty      = (out_count == '0);
    assign core_out_ready = !out_full && !ARESET;
    assign out_push_ok    = core_out_valid && core_out_ready;
    assign out_pop_ok     = out_pop && !out_empty;

    always_ff @(posedge ACLK) begin
        if (in_push_ok) in_mem[in_wr_ptr] <= in_din;
        if (out_push_ok) out_mem[out_wr_ptr] <= core_out_data;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            in_count   <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else begin
            if (in_push_ok) in_wr_ptr <= in_wr_ptr + 1'b1;
            if (in_pop_ok) in_rd_ptr <= in_rd_ptr + 1'b1;
            in_count <= in_count + IN_CW'(in_push_ok) - IN_CW'(in_pop_ok);
            if (out_push_ok) out_wr_ptr <= out_wr_ptr + 1'b1;
            if (out_pop_ok) out_rd_ptr <= out_rd_ptr + 1'b1;
            out_count <= out_count + OUT_CW'(out_push_ok) - OUT_CW'(out_pop_ok);
        end
    end

    // A transfer happens on a rising edge where VALID and READY are both high;
    // a source never withdraws VALID or changes its payload until that edge.
    assign w_bad = !((aw_addr_q == 8'h00) || (aw_addr_q == 8'h04));

    always_comb begin
        w_next  = w_state;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 2'b00;
        in_push = 1'b0;
        if (!ARESET) begin
            case (w_state)
                W_IDLE: begin
                    AWREADY = 1'b1;
                    if (AWVALID) w_next = W_DATA;
                end
                W_DATA: begin
                    WREADY = w_bad || !in_full;
                    if (WVALID && WREADY) begin
                        in_push = !w_bad;
                        if (WLAST) w_next = W_RESP;
                    end
                end
                W_RESP: begin
                    BVALID = 1'b1;
                    BRESP  = w_bad ? 2'b10 : 2'b00;
                    if (BREADY) w_next = W_IDLE;
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
        end else begin
            w_state <= w_next;
            if (AWVALID && AWREADY) aw_addr_q <= AWADDR[7:0];
        end
    end

    assign r_is_pop  = (ar_addr_q == 8'h08);
    assign r_is_stat = (ar_addr_q == 8'h0C);
    assign r_bad     = !(r_is_pop || r_is_stat);

    always_comb begin
        status        = '0;
        status[31:16] = 16'(in_count);
        status[15:0]  = 16'(out_count);
    end

    always_comb begin
        r_next     = r_state;
        ARREADY    = 1'b0;
        RVALID     = 1'b0;
        out_pop    = 1'b0;
        rdata_live = '0;
        if (!ARESET) begin
            case (r_state)
                R_IDLE: begin
                    ARREADY = 1'b1;
                    if (ARVALID) r_next = R_DATA;
                end
                R_DATA: begin
                    RVALID     = r_is_pop ? !out_empty : 1'b1;
                    rdata_live = r_is_pop ? out_mem[out_rd_ptr] : (r_is_stat ? status : '0);
                    if (RVALID && RREADY) begin
                        out_pop = r_is_pop;
                        if (r_cnt_q == 8'd0) r_next = R_IDLE;
                    end
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    // Status counts can move under a stalled beat, so the first stalled value is held.
    assign RDATA = RVALID ? (hold_v ? hold_d : rdata_live) : '0;
    assign RRESP = (RVALID && r_bad) ? 2'b10 : 2'b00;
    assign RLAST = RVALID && (r_cnt_q == 8'd0);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= R_IDLE;
            ar_addr_q <= '0;
            r_cnt_q   <= '0;
            hold_v    <= 1'b0;
            hold_d    <= '0;
        end else begin
            r_state <= r_next;
            if (ARVALID && ARREADY) begin
                ar_addr_q <= ARADDR[7:0];
                r_cnt_q   <= ARLEN;
            end else if (RVALID && RREADY) begin
                r_cnt_q <= r_cnt_q - 8'd1;
            end
            if (RVALID && !RREADY) begin
                hold_v <= 1'b1;
                if (!hold_v) hold_d <= rdata_live;
            end else begin
                hold_v <= 1'b0;
            end
        end
    end

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

endmodule

// File: tb/tb_axi_stream_hash_bridge.sv
// Directed bench for axi_stream_hash_bridge: bus bursts, core-side streams,
// status/error decode and mid-burst reset.
module tb_axi_stream_hash_bridge;
  localparam int W = 32;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [31:0] AWADDR, ARADDR;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [W-1:0] WDATA, RDATA, core_in_data, core_out_data;
  logic [1:0] BRESP, RRESP, w_state_dbg, r_state_dbg;
  logic [7:0] ARLEN;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic core_in_last, core_in_valid, core_in_ready;
  logic core_out_valid, core_out_ready;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  logic [W:0] e;

  always #5 ACLK = ~ACLK;

  axi_stream_hash_bridge #(.DATA_W(W), .IN_DEPTH(16), .OUT_DEPTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .core_in_data(core_in_data), .core_in_last(core_in_last),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_out_data(core_out_data), .core_out_valid(core_out_valid),
    .core_out_ready(core_out_ready),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] addr);
    @(negedge ACLK); AWADDR = addr; AWVALID = 1'b1; #1;
    for (int i = 0; i < 50 && !AWREADY; i++) begin @(negedge ACLK); #1; end
    check("awready", AWREADY, 1);
    @(negedge ACLK); AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [W-1:0] data, input logic last);
    @(negedge ACLK); WDATA = data; WLAST = last; WVALID = 1'b1; #1;
    for (int i = 0; i < 50 && !WREADY; i++) begin @(negedge ACLK); #1; end
    check("wready", WREADY, 1);
    @(negedge ACLK); WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic b_check(input logic [1:0] exp_resp);
    @(negedge ACLK); BREADY = 1'b1; #1;
    for (int i = 0; i < 50 && !BVALID; i++) begin @(negedge ACLK); #1; end
    check("bvalid", BVALID, 1);
    check("bresp", BRESP, exp_resp);
    @(negedge ACLK); BREADY = 1'b0; #1;
    check("bvalid_drop", BVALID, 0);
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len);
    @(negedge ACLK); ARADDR = addr; ARLEN = len; ARVALID = 1'b1; #1;
    for (int i = 0; i < 50 && !ARREADY; i++) begin @(negedge ACLK); #1; end
    check("arready", ARREADY, 1);
    @(negedge ACLK); ARVALID = 1'b0;
  endtask

  task automatic r_check(input logic [W-1:0] data, input logic last, input logic [1:0] resp);
    @(negedge ACLK); RREADY = 1'b1; #1;
    for (int i = 0; i < 50 && !RVALID; i++) begin @(negedge ACLK); #1; end
    check("rvalid", RVALID, 1);
    check("rdata", RDATA, data);
    check("rlast", RLAST, last);
    check("rresp", RRESP, resp);
    @(negedge ACLK); RREADY = 1'b0;
  endtask

  task automatic core_push(input logic [W-1:0] data);
    @(negedge ACLK); core_out_data = data; core_out_valid = 1'b1; #1;
    for (int i = 0; i < 50 && !core_out_ready; i++) begin @(negedge ACLK); #1; end
    check("core_out_ready", core_out_ready, 1);
    @(negedge ACLK); core_out_valid = 1'b0;
  endtask

  task automatic core_pop_check();
    @(negedge ACLK); core_in_ready = 1'b1; #1;
    for (int i = 0; i < 50 && !core_in_valid; i++) begin @(negedge ACLK); #1; end
    check("core_in_valid", core_in_valid, 1);
    e = exp_q.pop_front();
    check("core_in_data", core_in_data, e[W-1:0]);
    check("core_in_last", core_in_last, e[W]);
    @(negedge ACLK); core_in_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    core_in_ready = 1'b0; core_out_data = '0; core_out_valid = 1'b0;

    // Reset state
    @(negedge ACLK); @(negedge ACLK); #1;
    check("rst_awready", AWREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_core_in_valid", core_in_valid, 0);
    check("rst_core_out_ready", core_out_ready, 0);
    @(negedge ACLK); ARESET = 1'b0; #1;
    check("idle_awready", AWREADY, 1);
    check("idle_arready", ARREADY, 1);
    check("idle_core_out_ready", core_out_ready, 1);
    check("idle_w_state", w_state_dbg, 0);

    // Tagged burst at 0x04: only the final beat carries last
    aw_send(32'h04);
    w_send(32'hA1, 1'b0); exp_q.push_back({1'b0, 32'hA1});
    w_send(32'hA2, 1'b0); exp_q.push_back({1'b0, 32'hA2});
    w_send(32'hA3, 1'b1); exp_q.push_back({1'b1, 32'hA3});
    b_check(2'b00);
    for (int i = 0; i < 3; i++) core_pop_check();
    #1 check("drained_1", core_in_valid, 0);

    // Fill the input FIFO, 17th beat stalls until one pop
    aw_send(32'h00);
    for (int i = 0; i < 16; i++) begin
      w_send(32'hF000_0000 + i, 1'b0);
      exp_q.push_back({1'b0, 32'hF000_0000 + i});
    end
    @(negedge ACLK); WDATA = 32'hF000_0010; WLAST = 1'b1; WVALID = 1'b1; #1;
    check("wready_full_a", WREADY, 0);
    @(negedge ACLK); #1;
    check("wready_full_b", WREADY, 0);
    @(negedge ACLK); core_in_ready = 1'b1; #1;
    check("wready_full_pop", WREADY, 0);
    e = exp_q.pop_front();
    check("full_head", core_in_data, e[W-1:0]);
    @(negedge ACLK); core_in_ready = 1'b0; #1;
    check("wready_after_pop", WREADY, 1);
    exp_q.push_back({1'b0, 32'hF000_0010});
    @(negedge ACLK); WVALID = 1'b0; WLAST = 1'b0;
    b_check(2'b00);
    for (int i = 0; i < 16; i++) core_pop_check();
    #1 check("drained_2", core_in_valid, 0);

    // Output FIFO read with a stalled beat
    core_push(32'hD0); core_push(32'hD1); core_push(32'hD2); core_push(32'hD3);
    ar_send(32'h08, 8'd3);
    r_check(32'hD0, 1'b0, 2'b00);
    #1;
    check("stall_rvalid", RVALID, 1);
    check("stall_rdata_a", RDATA, 32'hD1);
    @(negedge ACLK); #1;
    check("stall_rdata_b", RDATA, 32'hD1);
    check("stall_rlast", RLAST, 0);
    r_check(32'hD1, 1'b0, 2'b00);
    r_check(32'hD2, 1'b0, 2'b00);
    r_check(32'hD3, 1'b1, 2'b00);
    #1;
    check("rd_done_rvalid", RVALID, 0);
    check("rd_done_arready", ARREADY, 1);

    // Underflow stall: second beat waits for the core
    core_push(32'hE0);
    ar_send(32'h08, 8'd1);
    r_check(32'hE0, 1'b0, 2'b00);
    @(negedge ACLK); RREADY = 1'b1; #1;
    check("empty_rvalid_a", RVALID, 0);
    @(negedge ACLK); #1;
    check("empty_rvalid_b", RVALID, 0);
    @(negedge ACLK); core_out_data = 32'hE1; core_out_valid = 1'b1; #1;
    check("empty_rvalid_c", RVALID, 0);
    @(negedge ACLK); core_out_valid = 1'b0; #1;
    check("late_rvalid", RVALID, 1);
    check("late_rdata", RDATA, 32'hE1);
    check("late_rlast", RLAST, 1);
    @(negedge ACLK); RREADY = 1'b0; #1;
    check("late_done", RVALID, 0);

    // Bad write address, then status and bad read
    aw_send(32'h20);
    w_send(32'hB0, 1'b0);
    w_send(32'hB1, 1'b1);
    b_check(2'b10);
    #1 check("bad_write_no_push", core_in_valid, 0);
    aw_send(32'h00);
    for (int i = 0; i < 5; i++) w_send(32'hC0 + i, i == 4);
    b_check(2'b00);
    core_push(32'h11); core_push(32'h22);
    ar_send(32'h0C, 8'd0);
    r_check(32'h0005_0002, 1'b1, 2'b00);
    ar_send(32'h10, 8'd1);
    r_check(32'h0, 1'b0, 2'b10);
    r_check(32'h0, 1'b1, 2'b10);

    // Reset mid-burst discards the burst and all queued words
    aw_send(32'h00);
    w_send(32'h77, 1'b0);
    @(negedge ACLK); ARESET = 1'b1; #1;
    check("mid_rst_awready", AWREADY, 0);
    @(negedge ACLK); ARESET = 1'b0; #1;
    check("post_rst_awready", AWREADY, 1);
    check("post_rst_bvalid", BVALID, 0);
    check("post_rst_core_in_valid", core_in_valid, 0);
    check("post_rst_w_state", w_state_dbg, 0);
    ar_send(32'h0C, 8'd0);
    r_check(32'h0, 1'b1, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
